slave_buffered: RTL and testbench
=================================

Name: slave_buffered

Overview:
- Buffered slave endpoint downstream of `multi_clock_arbiter`, in the clk300 domain.
- Replaces the bare `slave` instances on the arbiter's s_req/s_data/s_ack path.
- Accepts one word per four-phase req/ack transaction into a FIFO and drains it to a consumer over valid/ready.
- Keeps `last_data`, the most recently accepted word, so it can substitute for `slave`.

Parameters:
- DATA_W, 32: width of the data word.
- DEPTH, 4: FIFO entries. Power of two, ≥2.
- LVL_W, $clog2(DEPTH)+1: width of the `level` output. Derived; do not override.

Ports:
- clk  input  1  arbiter-domain clock.
- rst_n  input  1  asynchronous, active-low reset.
- req  input  1  request from arbiter. Held high with `data` stable until `ack` is seen.
- data  input  DATA_W  write word.
- ack  output  1  registered one-cycle accept pulse.
- last_data  output  DATA_W  last word accepted from upstream.
- out_valid  output  1  FIFO head valid (equals !empty).
- out_data  output  DATA_W  FIFO head word, first-word fall-through.
- out_ready  input  1  consumer accepts head this cycle.
- level  output  LVL_W  current occupancy, 0..DEPTH.
- full  output  1  level==DEPTH.
- empty  output  1  level==0.

Behaviour:
- Reset (async, rst_n=0):
  - ack=0, last_data=0, level=0, empty=1, full=0, out_valid=0.
  - Pointers=0, FSM=IDLE.
  - FIFO contents undefined. out_data don't-care while empty.
- Upstream FSM states: IDLE, ACK, WAIT_LOW.
  - IDLE:
    - req=1 and full=0 at a rising edge: write data to mem[wr_ptr], advance wr_ptr, last_data<=data, ack<=1, go to ACK.
    - req=1 and full=1: stay in IDLE, ack=0. Retry every cycle with no loss or duplication.
  - ACK: ack<=0. Go to WAIT_LOW if req=1, else IDLE.
  - WAIT_LOW: stay while req=1; go to IDLE when req=0. A held req never produces a second write.
- Latency and throughput:
  - req high in cycle N with space → ack high in cycle N+1.
  - out_valid high in cycle N+1 when the FIFO was empty.
  - Maximum upstream throughput: one word per 3 cycles when req drops immediately after ack.
- Pop: out_valid & out_ready at an edge advances rd_ptr. out_ready while empty has no effect.
- Level and full check:
  - Simultaneous push and pop: level unchanged, both pointers advance.
  - The full check uses pre-edge level. A push is refused even if a pop frees a slot in the same cycle; the push succeeds next cycle.
- Pointers: log2(DEPTH)-bit, wrap naturally. Empty/full derived from the level counter only.
- Ordering: strict FIFO. out_data = mem[rd_ptr] combinationally.
- Reset mid-transaction: FSM returns to IDLE and the FIFO empties.
  - If req is still high after reset release, it is treated as a new request and the word is written once.
- No X on any output after reset.

Optional Feature:
- Macro: SLV_BUF_STATS_EN.
- Defined: adds outputs
  - stat_accept [15:0]: increments on every upstream write.
  - stat_stall [15:0]: increments every cycle with FSM=IDLE & req=1 & full=1.
  - Both saturate at 16'hFFFF and clear on rst_n.
- Undefined: ports and logic absent. Behaviour otherwise identical.

Test Plan:
- Single write: reset, req=1 data=32'hA5A5_0001 held until ack → ack pulses exactly one cycle at N+1; last_data=32'hA5A5_0001; out_valid=1, out_data=32'hA5A5_0001, level=1; hold req 5 more cycles → level stays 1.
- Fill to full: out_ready=0, write 1,2,3,4 with DEPTH=4 → full=1, level=4. Fifth req=5 held → no ack, stat_stall counts stall cycles. Pulse out_ready one cycle → out_data 1 popped, ack for 5 arrives one cycle later. Drain order 2,3,4,5.
- Simultaneous push and pop: level=2, out_ready=1 in the same cycle a push is accepted → level stays 2, pointers advance, order preserved across wrap (≥10 words through DEPTH=4).
- Full-plus-pop edge case: full, out_ready=1 with req=1 in the same cycle → pop occurs, push refused that cycle, push accepted the next cycle, level=4 afterwards.
- Reset mid-operation: level=3 in ACK state, assert rst_n=0 for 2 cycles with req held high → all outputs at reset values. After release, exactly one write of the held data, level=1.
- Stats saturation (SLV_BUF_STATS_EN): force 70000 accepted words with out_ready=1 → stat_accept=16'hFFFF and does not wrap.

Source files
------------

// File: rtl/slave_buffered.sv
// Buffered four-phase req/ack slave: accepts words into a FIFO, drains over valid/ready.
// Optional statistics counters are enabled by defining SLV_BUF_STATS_EN.
module slave_buffered #(
  parameter  int DATA_W = 32,
  parameter  int DEPTH  = 4,
  localparam int LVL_W  = $clog2(DEPTH) + 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req,
  input  logic [DATA_W-1:0] data,
  output logic              ack,
  output logic [DATA_W-1:0] last_data,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data,
  input  logic              out_ready,
  output logic [LVL_W-1:0]  level,
  output logic              full,
  output logic              empty
`ifdef SLV_BUF_STATS_EN
  ,
  output logic [15:0]       stat_accept,
  output logic [15:0]       stat_stall
`endif
);

  localparam int PTR_W = $clog2(DEPTH);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ACK,
    S_WAIT_LOW
  } state_t;

  state_t              r_state;
  state_t              w_next_state;
  logic                w_ack;
  logic                w_push;
  logic                w_pop;
  logic                w_full;
  logic                w_empty;

  logic [DATA_W-1:0]   r_mem [DEPTH];
  logic [PTR_W-1:0]    r_wr_ptr;
  logic [PTR_W-1:0]    r_rd_ptr;
  logic [LVL_W-1:0]    r_level;
  logic [DATA_W-1:0]   r_last_data;

  // Full/empty come from the pre-edge level only, so a pop never frees a slot
  // for a push in the same cycle.
  assign w_full  = (r_level == LVL_W'(DEPTH));
  assign w_empty = (r_level == '0);
  assign w_pop   = !w_empty && out_ready;

  // NOTE: state and all sequential state use non-blocking assignments.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next_state;
  end

  // NOTE: default assignment first so no path leaves the signal unassigned (no latch).
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE:     if (req && !w_full) w_next_state = S_ACK;
      S_ACK:      w_next_state = req ? S_WAIT_LOW : S_IDLE;
      S_WAIT_LOW: if (!req) w_next_state = S_IDLE;
      default:    w_next_state = S_IDLE;
    endcase
  end

  // ack is decoded from the state register, so it is a registered, glitch-free pulse.
  always_comb begin
    w_ack  = (r_state == S_ACK);
    w_push = (r_state == S_IDLE) && req && !w_full;
  end

  // NOTE: storage is deliberately not reset; occupancy is tracked by r_level.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_level     <= '0;
      r_last_data <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr    <= r_wr_ptr + PTR_W'(1);
        r_last_data <= data;
      end
      if (w_pop) r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      case ({w_push, w_pop})
        2'b10:   r_level <= r_level + LVL_W'(1);
        2'b01:   r_level <= r_level - LVL_W'(1);
        default: r_level <= r_level;
      endcase
    end
  end

`ifdef SLV_BUF_STATS_EN
  logic [15:0] r_stat_accept;
  logic [15:0] r_stat_stall;
  logic        w_stall;

  assign w_stall = (r_state == S_IDLE) && req && w_full;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_stat_accept <= '0;
      r_stat_stall  <= '0;
    end else begin
      if (w_push && (r_stat_accept != 16'hFFFF)) r_stat_accept <= r_stat_accept + 16'd1;
      if (w_stall && (r_stat_stall != 16'hFFFF)) r_stat_stall  <= r_stat_stall + 16'd1;
    end
  end

  assign stat_accept = r_stat_accept;
  assign stat_stall  = r_stat_stall;
`endif

  // Head word is masked to zero while empty so the output never shows X.
  assign out_data  = w_empty ? '0 : r_mem[r_rd_ptr];
  assign ack       = w_ack;
  assign last_data = r_last_data;
  assign out_valid = !w_empty;
  assign level     = r_level;
  assign full      = w_full;
  assign empty     = w_empty;

endmodule

// File: tb/tb_slave_buffered.sv
// Scoreboard bench for slave_buffered: expected words queue on drive, compare on pop.
module tb_slave_buffered;

  localparam int DATA_W = 32;
  localparam int DEPTH  = 4;
  localparam int LVL_W  = $clog2(DEPTH) + 1;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              req;
  logic [DATA_W-1:0] data;
  logic              ack;
  logic [DATA_W-1:0] last_data;
  logic              out_valid;
  logic [DATA_W-1:0] out_data;
  logic              out_ready;
  logic [LVL_W-1:0]  level;
  logic              full;
  logic              empty;
`ifdef SLV_BUF_STATS_EN
  logic [15:0]       stat_accept;
  logic [15:0]       stat_stall;
`endif

  int                n_checks = 0;
  int                n_fail   = 0;
  logic [DATA_W-1:0] sb [$];

  slave_buffered #(.DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req       (req),
    .data      (data),
    .ack       (ack),
    .last_data (last_data),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_ready (out_ready),
    .level     (level),
    .full      (full),
    .empty     (empty)
`ifdef SLV_BUF_STATS_EN
    ,
    .stat_accept (stat_accept),
    .stat_stall  (stat_stall)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // Consumer side: every pop is compared against the oldest expected word.
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      if (sb.size() == 0) check("sb_underflow", 32'd1, 32'd0);
      else                check("out_data", out_data, sb.pop_front());
    end
  end

  // One four-phase transaction; with pop_too the consumer pops in the accept cycle.
  task automatic push_word(input logic [31:0] d, input bit pop_too);
    bit got;
    @(posedge clk); #1;
    req  = 1'b1;
    data = d;
    sb.push_back(d);
    if (pop_too) begin
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
    end
    got = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (ack) begin
        got = 1'b1;
        break;
      end
    end
    check("ack_seen", 32'(got), 32'd1);
    if (pop_too) check("level_pushpop", 32'(level), 32'd2);
    @(posedge clk); #1;
    req = 1'b0;
  endtask

  task automatic drain();
    @(posedge clk); #1;
    out_ready = 1'b1;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (empty) break;
    end
    #1 out_ready = 1'b0;
    check("drain_empty", 32'(empty), 32'd1);
    check("sb_empty", 32'(sb.size()), 32'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    rst_n     = 1'b0;
    req       = 1'b0;
    data      = '0;
    out_ready = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_ack",       32'(ack),       32'd0);
    check("rst_last_data", last_data,      32'd0);
    check("rst_level",     32'(level),     32'd0);
    check("rst_empty",     32'(empty),     32'd1);
    check("rst_full",      32'(full),      32'd0);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    // Single write: ack exactly one cycle after the sampling edge, held req writes once.
    @(posedge clk); #1;
    req  = 1'b1;
    data = 32'hA5A5_0001;
    sb.push_back(32'hA5A5_0001);
    @(negedge clk);
    check("single_ack_pre", 32'(ack), 32'd0);
    @(negedge clk);
    check("single_ack",       32'(ack),       32'd1);
    check("single_last_data", last_data,      32'hA5A5_0001);
    check("single_out_valid", 32'(out_valid), 32'd1);
    check("single_out_data",  out_data,       32'hA5A5_0001);
    check("single_level",     32'(level),     32'd1);
    @(negedge clk);
    check("single_ack_drop", 32'(ack), 32'd0);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("single_hold_level", 32'(level), 32'd1);
      check("single_hold_ack",   32'(ack),   32'd0);
    end
    @(posedge clk); #1;
    req = 1'b0;
    drain();

    // Fill to full, then stall a fifth request.
    for (int i = 1; i <= 4; i++) push_word(32'(i), 1'b0);
    @(negedge clk);
    check("fill_full",  32'(full),  32'd1);
    check("fill_level", 32'(level), 32'd4);
`ifdef SLV_BUF_STATS_EN
    check("stat_accept_5", 32'(stat_accept), 32'd5);
`endif
    @(posedge clk); #1;
    req  = 1'b1;
    data = 32'd5;
    sb.push_back(32'd5);
    repeat (5) @(negedge clk);
    check("stall_no_ack", 32'(ack),   32'd0);
    check("stall_level",  32'(level), 32'd4);
`ifdef SLV_BUF_STATS_EN
    check("stat_stall_nz", 32'(stat_stall != 16'd0), 32'd1);
`endif

    // Full plus pop in the same cycle: pop happens, push waits one more cycle.
    @(posedge clk); #1;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    @(negedge clk);
    check("fullpop_ack",   32'(ack),   32'd0);
    check("fullpop_level", 32'(level), 32'd3);
    @(negedge clk);
    check("retry_ack",   32'(ack),   32'd1);
    check("retry_level", 32'(level), 32'd4);
    @(posedge clk); #1;
    req = 1'b0;
    drain();

    // Simultaneous push and pop at level 2, streaming across pointer wrap.
    push_word(32'h100, 1'b0);
    push_word(32'h101, 1'b0);
    for (int i = 0; i < 12; i++) push_word(32'h200 + 32'(i), 1'b1);
    @(negedge clk);
    check("pushpop_final_level", 32'(level), 32'd2);
    drain();

    // Reset mid-transaction with req held: FIFO flushes, held word written once after release.
    push_word(32'h300, 1'b0);
    push_word(32'h301, 1'b0);
    @(posedge clk); #1;
    req  = 1'b1;
    data = 32'h302;
    repeat (2) @(negedge clk);
    check("mid_ack",   32'(ack),   32'd1);
    check("mid_level", 32'(level), 32'd3);
    #1 rst_n = 1'b0;
    sb.delete();
    repeat (2) @(negedge clk);
    check("mid_rst_ack",       32'(ack),       32'd0);
    check("mid_rst_level",     32'(level),     32'd0);
    check("mid_rst_empty",     32'(empty),     32'd1);
    check("mid_rst_out_valid", 32'(out_valid), 32'd0);
    check("mid_rst_last_data", last_data,      32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    sb.push_back(32'h302);
    @(negedge clk);
    check("post_rst_ack_pre", 32'(ack), 32'd0);
    @(negedge clk);
    check("post_rst_ack",       32'(ack),   32'd1);
    check("post_rst_level",     32'(level), 32'd1);
    check("post_rst_last_data", last_data,  32'h302);
    repeat (4) @(negedge clk);
    check("post_rst_hold_level", 32'(level), 32'd1);
    @(posedge clk); #1;
    req = 1'b0;
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
